ramp_sequencer_ctrl: RTL and testbench



---
 rtl/fsm_pkg.sv | 32 +++
 rtl/tick_gen.sv | 34 +++
 rtl/ramp_sequencer_ctrl.sv | 153 +++++++++++++++
 tb/tb_ramp_sequencer_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/fsm_pkg.sv
// Shared state encoding and drive-level codes for the soft-start ramp sequencer.
// D50/D30 are only reachable when RAMP_DOWN_EN is defined.
package fsm_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    S30  = 3'd1,
    S50  = 3'd2,
    S100 = 3'd3,
    D50  = 3'd4,
    D30  = 3'd5
  } state_e;

  localparam logic [1:0] LVL_OFF = 2'd0;
  localparam logic [1:0] LVL_30  = 2'd1;
  localparam logic [1:0] LVL_50  = 2'd2;
  localparam logic [1:0] LVL_100 = 2'd3;

  // Ramp-down stages reuse the drive level of the matching ramp-up stage.
  function automatic logic [1:0] level_of(input state_e s);
    logic [1:0] lvl;
    lvl = LVL_OFF;
    case (s)
      S30, D30: lvl = LVL_30;
      S50, D50: lvl = LVL_50;
      S100:     lvl = LVL_100;
      default:  lvl = LVL_OFF;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler producing a one-cycle tick every CLK_DIV clocks; clr forces the
// count back to 0 so every stage starts on a whole tick period.
module tick_gen #(
  parameter int unsigned CLK_DIV = 100000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick = (cnt_q == CW'(CLK_DIV - 1));

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ramp_sequencer_ctrl.sv
// Motor soft-start sequencer: 30% -> 50% -> 100% drive stages timed in ticks.
// Define RAMP_DOWN_EN to step back down through 50%/30% on stop instead of
// dropping straight to IDLE.
module ramp_sequencer_ctrl
  import fsm_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 100000000,
  parameter int unsigned DWELL_FAST = 2,
  parameter int unsigned DWELL_SLOW = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       fast,
  input  logic       slow,
  output logic       out_30,
  output logic       out_50,
  output logic       out_100,
  output logic [1:0] level,
  output logic       busy,
  output logic       tick
);

  localparam int unsigned DMAX = (DWELL_FAST > DWELL_SLOW) ? DWELL_FAST : DWELL_SLOW;
  localparam int unsigned DW   = (DMAX > 1) ? $clog2(DMAX) : 1;

  state_e        state_q;
  state_e        state_d;
  logic [DW-1:0] dwell_q;
  logic [DW-1:0] dwell_d;
  logic          mode_fast_q;
  logic          mode_fast_d;

  logic          tick_w;
  logic          clr;
  logic          advance;
  logic [DW-1:0] dwell_step;
  logic [DW-1:0] reload;

  // Counter is held in IDLE and restarted on every state change, so each
  // stage spans exactly DWELL*CLK_DIV cycles.
  assign clr = (state_q == IDLE) || (state_d != state_q);

  tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .tick  (tick_w)
  );

  assign reload     = mode_fast_q ? DW'(DWELL_FAST - 1) : DW'(DWELL_SLOW - 1);
  assign advance    = tick_w && (dwell_q == '0);
  assign dwell_step = (tick_w && (dwell_q != '0)) ? (dwell_q - DW'(1)) : dwell_q;

  always_comb begin
    state_d     = state_q;
    dwell_d     = dwell_q;
    mode_fast_d = mode_fast_q;
    case (state_q)
      IDLE: begin
        if (start && !stop && (fast || slow)) begin
          state_d     = S30;
          mode_fast_d = fast;
          dwell_d     = fast ? DW'(DWELL_FAST - 1) : DW'(DWELL_SLOW - 1);
        end
      end
      S30: begin
        if (stop) begin
          state_d = IDLE;
          dwell_d = '0;
        end else if (advance) begin
          state_d = S50;
          dwell_d = reload;
        end else begin
          dwell_d = dwell_step;
        end
      end
      S50: begin
        if (stop) begin
`ifdef RAMP_DOWN_EN
          state_d = D30;
          dwell_d = reload;
`else
          state_d = IDLE;
          dwell_d = '0;
`endif
        end else if (advance) begin
          state_d = S100;
          dwell_d = reload;
        end else begin
          dwell_d = dwell_step;
        end
      end
      S100: begin
        if (stop) begin
`ifdef RAMP_DOWN_EN
          state_d = D50;
          dwell_d = reload;
`else
          state_d = IDLE;
          dwell_d = '0;
`endif
        end
      end
`ifdef RAMP_DOWN_EN
      // Ramp-down ignores both start and stop until it reaches IDLE.
      D50: begin
        if (advance) begin
          state_d = D30;
          dwell_d = reload;
        end else begin
          dwell_d = dwell_step;
        end
      end
      D30: begin
        if (advance) begin
          state_d = IDLE;
          dwell_d = '0;
        end else begin
          dwell_d = dwell_step;
        end
      end
`endif
      default: begin
        state_d = IDLE;
        dwell_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      dwell_q     <= '0;
      mode_fast_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      dwell_q     <= dwell_d;
      mode_fast_q <= mode_fast_d;
    end
  end

  assign level   = level_of(state_q);
  assign out_30  = (level == LVL_30);
  assign out_50  = (level == LVL_50);
  assign out_100 = (level == LVL_100);
  assign busy    = (state_q != IDLE);
  assign tick    = tick_w;

endmodule

// File: tb/tb_ramp_sequencer_ctrl.sv
// Directed bench for ramp_sequencer_ctrl with CLK_DIV=4, DWELL_FAST=2, DWELL_SLOW=3;
// expectations follow RAMP_DOWN_EN when the bench is built with it defined.
module tb_ramp_sequencer_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       stop;
  logic       fast;
  logic       slow;
  logic       out_30;
  logic       out_50;
  logic       out_100;
  logic [1:0] level;
  logic       busy;
  logic       tick;

  int n_chk  = 0;
  int n_fail = 0;

  // {busy, out_100, out_50, out_30, level}
  localparam logic [5:0] E_IDLE = 6'b0_000_00;
  localparam logic [5:0] E_30   = 6'b1_001_01;
  localparam logic [5:0] E_50   = 6'b1_010_10;
  localparam logic [5:0] E_100  = 6'b1_100_11;

  ramp_sequencer_ctrl #(
    .CLK_DIV    (4),
    .DWELL_FAST (2),
    .DWELL_SLOW (3)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .stop    (stop),
    .fast    (fast),
    .slow    (slow),
    .out_30  (out_30),
    .out_50  (out_50),
    .out_100 (out_100),
    .level   (level),
    .busy    (busy),
    .tick    (tick)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] obs();
    return {tick, busy, out_100, out_50, out_30, level};
  endfunction

  task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  // Checks cycles first..last of a stage at successive falling edges; tick is
  // expected on every 4th cycle counted from stage entry.
  task automatic stage(input string tag, input logic [5:0] e,
                       input int unsigned first, input int unsigned last);
    for (int unsigned k = first; k <= last; k++) begin
      @(negedge clk);
      chk($sformatf("%s[%0d]", tag, k), obs(), {(k % 4 == 0), e});
    end
  endtask

  task automatic idle(input string tag);
    @(negedge clk);
    chk(tag, obs(), {1'b0, E_IDLE});
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b1;
    fast  = 1'b1;
    slow  = 1'b0;
    stop  = 1'b0;

    // Reset held with start/fast high: nothing moves.
    idle("rst_hold0");
    idle("rst_hold1");
    rst_n = 1'b1;

    // Fast ramp; mode switched to slow mid-ramp must not change the dwell.
    stage("f_s30", E_30, 1, 1);
    start = 1'b0;
    fast  = 1'b0;
    slow  = 1'b1;
    stage("f_s30", E_30, 2, 8);
    stage("f_s50", E_50, 1, 8);
    stage("f_s100", E_100, 1, 5);
    stop = 1'b1;
`ifdef RAMP_DOWN_EN
    stage("f_d50", E_50, 1, 1);
    stop = 1'b0;
    stage("f_d50", E_50, 2, 8);
    stage("f_d30", E_30, 1, 8);
    idle("f_down_idle");
`else
    idle("f_stop_idle");
    stop = 1'b0;
`endif
    idle("f_idle2");

    // Slow-only ramp.
    start = 1'b1;
    stage("s_s30", E_30, 1, 1);
    start = 1'b0;
    stage("s_s30", E_30, 2, 12);
    stage("s_s50", E_50, 1, 12);
    stage("s_s100", E_100, 1, 2);
    stop = 1'b1;
`ifdef RAMP_DOWN_EN
    stage("s_d50", E_50, 1, 1);
    stop = 1'b0;
    stage("s_d50", E_50, 2, 12);
    stage("s_d30", E_30, 1, 12);
    idle("s_down_idle");
`else
    idle("s_stop_idle");
    stop = 1'b0;
`endif

    // No mode selected: start ignored.
    fast  = 1'b0;
    slow  = 1'b0;
    start = 1'b1;
    idle("nomode0");
    idle("nomode1");
    idle("nomode2");

    // start and stop together in IDLE: stop wins.
    fast = 1'b1;
    stop = 1'b1;
    idle("startstop0");
    idle("startstop1");
    start = 1'b0;
    stop  = 1'b0;
    idle("startstop2");

    // Stop on the cycle S30 would advance: stop wins.
    start = 1'b1;
    stage("adv_s30", E_30, 1, 1);
    start = 1'b0;
    stage("adv_s30", E_30, 2, 8);
    stop = 1'b1;
    idle("adv_stop");
    stop = 1'b0;

    // Stop at cycle 5 of S50 in fast mode.
    start = 1'b1;
    stage("m_s30", E_30, 1, 1);
    start = 1'b0;
    stage("m_s30", E_30, 2, 8);
    stage("m_s50", E_50, 1, 5);
    stop = 1'b1;
`ifdef RAMP_DOWN_EN
    stage("m_d30", E_30, 1, 1);
    stop = 1'b0;
    stage("m_d30", E_30, 2, 8);
    idle("m_down_idle");
`else
    idle("m_stop_idle");
    stop = 1'b0;
`endif

    // Start held through a stop re-triggers on the cycle after IDLE.
    start = 1'b1;
    stage("r_s30", E_30, 1, 1);
    stop = 1'b1;
    idle("r_stop");
    stop = 1'b0;
    stage("r_retrig", E_30, 1, 1);
    start = 1'b0;
    stage("r_s30", E_30, 2, 8);
    stage("r_s50", E_50, 1, 3);

    // Asynchronous reset between clock edges during S50.
    #2 rst_n = 1'b0;
    #1 chk("async_rst", obs(), {1'b0, E_IDLE});
    idle("async_hold");
    rst_n = 1'b1;
    idle("async_release");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
